// File: rtl/iterative_alu_if.sv
// Request/response bundle between the control path and the iterative ALU.
// The master issues a start with its operands. The slave reports busy/done and the registered result.
interface iterative_alu_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [3:0]       ALU_Operation_i;
    logic [WIDTH-1:0] A_i;
    logic [WIDTH-1:0] B_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] ALU_Result_o;
    logic             Zero_o;

    modport master (
        output start_i, ALU_Operation_i, A_i, B_i,
        input  busy_o, done_o, ALU_Result_o, Zero_o
    );

    modport slave (
        input  start_i, ALU_Operation_i, A_i, B_i,
        output busy_o, done_o, ALU_Result_o, Zero_o
    );
endinterface

// File: rtl/iterative_alu.sv
// Multi-cycle ALU. Logic and arithmetic ops finish in one cycle.
// Shifts move one bit per cycle, so no barrel shifter is needed.
module iterative_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    iterative_alu_if.slave    bus
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_LUI = 4'b1001;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   result;

    logic [SHAMT_W-1:0] shamt;
    logic               is_shift_op;
    logic [WIDTH-1:0]   single_result;
    logic [WIDTH-1:0]   shifted_acc;

    assign shamt       = bus.B_i[SHAMT_W-1:0];
    assign is_shift_op = (bus.ALU_Operation_i == OP_SLL) ||
                         (bus.ALU_Operation_i == OP_SRL) ||
                         (bus.ALU_Operation_i == OP_SRA);

    // Single-cycle result. A shift reaches this path only with amount 0, so it passes A through.
    always_comb begin
        // NOTE: default assignment first, so no path through the block leaves the output unassigned (no latch).
        single_result = '0;
        unique case (bus.ALU_Operation_i)
            OP_ADD:                 single_result = bus.A_i + bus.B_i;
            OP_SUB:                 single_result = bus.A_i - bus.B_i;
            OP_AND:                 single_result = bus.A_i & bus.B_i;
            OP_OR:                  single_result = bus.A_i | bus.B_i;
            OP_XOR:                 single_result = bus.A_i ^ bus.B_i;
            OP_SLL, OP_SRL, OP_SRA: single_result = bus.A_i;
            OP_LUI:                 single_result = bus.B_i;
            default:                single_result = '0;
        endcase
    end

    // One-bit step of the latched shift.
    always_comb begin
        shifted_acc = acc;
        unique case (op_q)
            OP_SLL:  shifted_acc = {acc[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted_acc = {1'b0, acc[WIDTH-1:1]};
            OP_SRA:  shifted_acc = {acc[WIDTH-1], acc[WIDTH-1:1]};
            default: shifted_acc = acc;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            acc    <= '0;
            cnt    <= '0;
            op_q   <= OP_ADD;
            result <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        if (is_shift_op && (shamt != '0)) begin
                            acc   <= bus.A_i;
                            cnt   <= shamt;
                            op_q  <= bus.ALU_Operation_i;
                            state <= ST_SHIFT;
                        end else begin
                            result <= single_result;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc <= shifted_acc;
                    cnt <= cnt - SHAMT_W'(1);
                    // cnt is tested before it is decremented, so it never wraps past zero.
                    if (cnt == SHAMT_W'(1)) begin
                        result <= shifted_acc;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o       = (state != ST_IDLE);
    assign bus.done_o       = (state == ST_DONE);
    assign bus.ALU_Result_o = result;
    assign bus.Zero_o       = (result == '0);

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_iterative_alu;

    localparam int WIDTH = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    iterative_alu_if #(.WIDTH(WIDTH)) bus ();

    iterative_alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] model_result = '0;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        int unsigned sh;
        sh = b % WIDTH;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd6:    return a << sh;
            4'd7:    return a >> sh;
            4'd8:    return $unsigned($signed(a) >>> sh);
            4'd9:    return b;
            default: return '0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [WIDTH-1:0] b);
        int unsigned sh;
        sh = b % WIDTH;
        if ((op == 4'd6 || op == 4'd7 || op == 4'd8) && sh != 0) return int'(sh) + 1;
        return 1;
    endfunction

    // Called at posedge+#1 with the DUT idle; returns at posedge+#1 with the DUT idle again.
    task automatic run_op(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit noise);
        logic [WIDTH-1:0] exp_r;
        int exp_lat;
        int lat;
        exp_r   = ref_alu(op, a, b);
        exp_lat = ref_latency(op, b);
        bus.start_i = 1'b1;
        bus.ALU_Operation_i = op;
        bus.A_i = a;
        bus.B_i = b;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        if (noise) begin
            bus.ALU_Operation_i = 4'($urandom);
            bus.A_i = $urandom;
            bus.B_i = $urandom;
        end
        lat = 1;
        while (bus.done_o !== 1'b1 && lat <= WIDTH + 4) begin
            check("busy_in_shift", bus.busy_o, 1);
            check("hold_in_shift", bus.ALU_Result_o, model_result);
            if (noise) begin
                bus.start_i = 1'($urandom_range(0, 1));
                bus.ALU_Operation_i = 4'($urandom);
                bus.A_i = $urandom;
                bus.B_i = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("result", bus.ALU_Result_o, exp_r);
        check("zero", bus.Zero_o, (exp_r == '0));
        check("busy_in_done", bus.busy_o, 1);
        model_result = exp_r;
        bus.start_i = noise;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        check("idle_after_done", {bus.busy_o, bus.done_o}, 2'b00);
        check("hold_after_done", bus.ALU_Result_o, model_result);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int done_seen;
        bus.start_i = 1'b0;
        bus.ALU_Operation_i = 4'd0;
        bus.A_i = '0;
        bus.B_i = '0;

        // Reset held with start toggling
        repeat (4) begin
            @(negedge clk);
            bus.start_i = ~bus.start_i;
            bus.ALU_Operation_i = 4'd9;
            bus.B_i = 32'hDEAD_BEEF;
        end
        #1;
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_result", bus.ALU_Result_o, 0);
        check("rst_zero", bus.Zero_o, 1);
        bus.start_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(4'b0000, 32'd5, 32'd7, 1'b0);
        run_op(4'b0001, 32'h1234, 32'h1234, 1'b0);
        run_op(4'b1000, 32'h8000_0000, 32'd4, 1'b0);
        run_op(4'b0111, 32'h8000_0000, 32'd4, 1'b0);
        run_op(4'b0110, 32'd1, 32'd0, 1'b0);
        run_op(4'b0110, 32'd1, 32'hFFFF_FFFF, 1'b0);
        run_op(4'b1001, 32'h0, 32'hABCD_E000, 1'b0);
        run_op(4'b0101, 32'hFFFF_FFFF, 32'h1, 1'b0);
        // Spurious starts and operand churn during a shift, then a back-to-back start
        run_op(4'b1000, 32'hC3A5_0F0F, 32'd9, 1'b1);
        run_op(4'b0100, 32'hFFFF_0000, 32'h00FF_FF00, 1'b0);

        // Reset in cycle 3 of a 10-bit shift
        bus.start_i = 1'b1;
        bus.ALU_Operation_i = 4'b0111;
        bus.A_i = 32'hFFFF_FFFF;
        bus.B_i = 32'd10;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midrst_busy", bus.busy_o, 0);
        check("midrst_done", bus.done_o, 0);
        check("midrst_result", bus.ALU_Result_o, 0);
        check("midrst_zero", bus.Zero_o, 1);
        model_result = '0;
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done_o === 1'b1) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        run_op(4'b0110, 32'h0000_0003, 32'd3, 1'b0);

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            op = (i % 3 == 0) ? 4'(6 + $urandom_range(0, 2)) : 4'($urandom);
            run_op(op, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
